// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/carry_lookahead_4bit.sv
// 4-bit carry-lookahead slice; purely combinational, no handshake.
// Exposes group propagate/generate so the caller can form the slice carry-out.
module carry_lookahead_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       Pg,
    output logic       Gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign Pg  = &p;
    assign Gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that runs one nibble per cycle through a single CLA slice; result valid NIB cycles after accept.
// Result is held stable in DONE until out_ready; no new operand is accepted until the result is consumed.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 carry_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;
    logic                 ovf_q;

    logic [SLICE_W-1:0]   a_nib;
    logic [SLICE_W-1:0]   b_nib;
    logic [SLICE_W-1:0]   nib_sum;
    logic                 pg;
    logic                 gg;
    logic                 new_carry;
    logic [WIDTH-1:0]     sum_next;

    // Shift-based nibble select keeps the WIDTH=4 case free of out-of-range part-selects.
    assign a_nib     = SLICE_W'(a_q >> (idx * SLICE_W));
    assign b_nib     = SLICE_W'(b_q >> (idx * SLICE_W));
    assign new_carry = gg | (pg & carry_q);
    assign sum_next  = (sum_q & ~(WIDTH'({SLICE_W{1'b1}}) << (idx * SLICE_W)))
                     | (WIDTH'(nib_sum) << (idx * SLICE_W));

    carry_lookahead_4bit u_slice (
        .a   (a_nib),
        .b   (b_nib),
        .cin (carry_q),
        .sum (nib_sum),
        .Pg  (pg),
        .Gg  (gg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= new_carry;
                    if (idx == LAST_IDX) begin
                        cout_q <= new_carry;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (nib_sum[SLICE_W-1] != a_q[WIDTH-1]);
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = rst_n && (state == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: fixed vectors, multi-cycle corner sequences and
// randomized operations against an arithmetic reference, for WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, cout, overflow;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4, overflow4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .overflow(overflow4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition of the operands as captured at accept.
    task automatic model(input int w, input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         output logic [15:0] es, output logic ec, output logic eo);
        int unsigned full;
        int unsigned mask;
        mask = (1 << w) - 1;
        full = (int'(ta) & mask) + (int'(tb) & mask) + int'(tc);
        es   = 16'(full & mask);
        ec   = full[w];
        eo   = (ta[w-1] == tb[w-1]) && (full[w-1] != ta[w-1]);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input bit scramble, input int hold,
                         output logic [15:0] rs, output logic rc, output logic ro);
        int lat;
        int w;
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept16", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("out_valid16", {31'd0, out_valid}, 32'd1);
        check("latency16", lat, 32'd4);
        rs = sum; rc = cout; ro = overflow;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_result", {15'd0, overflow, cout, sum}, {15'd0, ro, rc, rs});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed16", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                        output logic [3:0] rs, output logic rc, output logic ro);
        int lat;
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
        check("accept4", {31'd0, in_ready4}, 32'd1);
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            if (out_valid4) break;
            @(posedge clk);
            lat++;
        end
        check("out_valid4", {31'd0, out_valid4}, 32'd1);
        check("latency4", lat, 32'd1);
        rs = sum4; rc = cout4; ro = overflow4;
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
        check("consumed4", {30'd0, out_valid4, in_ready4}, 32'd1);
    endtask

    initial begin
        vec_t        tbl [6];
        logic [15:0] rs, es;
        logic [3:0]  rs4;
        logic        rc, ro, ec, eo;
        bit          seen;
        logic [15:0] ra, rb;
        logic        rcin;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {15'd0, overflow, cout, sum}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            run16(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 0, rs, rc, ro);
            check($sformatf("tbl%0d_sum", i), {16'd0, rs}, {16'd0, tbl[i].sum});
            check($sformatf("tbl%0d_cout", i), {31'd0, rc}, {31'd0, tbl[i].cout});
            check($sformatf("tbl%0d_ovf", i), {31'd0, ro}, {31'd0, tbl[i].ovf});
        end

        // Downstream stall for five cycles in DONE.
        run16(16'hABCD, 16'h1111, 1'b0, 1'b0, 5, rs, rc, ro);
        check("bp_sum", {16'd0, rs}, 32'h0000BCDE);

        // Operand inputs thrash while the slice is working.
        run16(16'h0F0F, 16'h1010, 1'b1, 1'b1, 0, rs, rc, ro);
        check("scramble_sum", {15'd0, rc, rs}, 32'h00001F20);

        // Reset after two nibbles have been processed.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        check("midrst_sum", {15'd0, overflow, cout, sum}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", {31'd0, seen}, 32'd0);
        run16(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
        check("after_rst_sum", {15'd0, rc, rs}, 32'h00000100);

        for (int i = 0; i < 120; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
            model(16, ra, rb, rcin, es, ec, eo);
            run16(ra, rb, rcin, 1'($urandom), int'($urandom_range(0, 2)), rs, rc, ro);
            check($sformatf("rand%0d", i), {14'd0, ro, rc, rs}, {14'd0, eo, ec, es});
        end

        run4(4'hF, 4'hF, 1'b1, rs4, rc, ro);
        check("w4_spec", {26'd0, ro, rc, rs4}, {26'd0, 1'b0, 1'b1, 4'hF});
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); rcin = 1'($urandom);
            model(4, ra, rb, rcin, es, ec, eo);
            run4(ra[3:0], rb[3:0], rcin, rs4, rc, ro);
            check($sformatf("w4_rand%0d", i), {26'd0, ro, rc, rs4}, {26'd0, eo, ec, es[3:0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder for operands wider than one 4-bit lookahead slice. It captures a WIDTH-bit operand pair under a valid/ready handshake and feeds one nibble per cycle, LSB first, through a single `carry_lookahead_4bit` slice. Between nibbles it registers the slice carry-out, which it derives from the slice group signals. It assembles the full sum, carry-out and signed overflow, and presents them downstream on a second valid/ready handshake. This makes it the sequencing stage wrapped around the CLA slice: an area-optimised alternative to a hierarchical lookahead tree.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4 and at least 4. Derived: `NIB = WIDTH/4` slice cycles per operation.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: operand pair and `cin` are valid.
- `in_ready`, out, 1: block can accept an operation; high only in IDLE.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `cin`, in, 1: carry-in into nibble 0.
- `out_valid`, out, 1: result valid; high only in DONE.
- `out_ready`, in, 1: downstream accepts the result.
- `sum`, out, WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`, out, 1: carry out of bit WIDTH-1.
- `overflow`, out, 1: two's-complement overflow, defined as `a[MSB]==b[MSB]` and `sum[MSB]!=a[MSB]`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid & in_ready`: register `a` and `b`, set carry reg to `cin`, set nibble index to 0, go to RUN.
- **RUN:**
  - Each cycle, slice inputs are `a_reg[4*idx+:4]`, `b_reg[4*idx+:4]` and the carry reg.
  - The slice sum is written into `sum_reg[4*idx+:4]`.
  - New carry = `Gg | (Pg & carry_reg)`.
  - idx increments by 1.
  - When `idx==NIB-1`, the final carry is loaded into `cout` and `overflow` is computed from the registered MSBs, then go to DONE.
  - `in_valid` is ignored in RUN.
- **DONE:**
  - `out_valid=1`.
  - `sum`, `cout` and `overflow` stay stable while `out_valid & !out_ready`.
  - On `out_ready`: go to IDLE.
- **Index counter:** width `max(1,$clog2(NIB))`. It never wraps inside an operation and is cleared on every accept.
- **WIDTH=4 (NIB=1):** RUN lasts exactly one cycle.
- **Input capture:** operands are captured once, so input changes after the accept edge have no effect on the result.

## Timing
- **Reset:**
  - While `rst_n` is low at an edge: state to IDLE; idx, carry reg, `sum`, `cout` and `overflow` to 0.
  - `out_valid=0`. `in_ready` is forced to 0 while `rst_n=0`, and is 1 in the first cycle after reset is released.
- **Latency:** an accept at edge E0 gives `out_valid` high after edge E0+NIB (4 cycles for WIDTH=16).
- **Throughput:**
  - The result is consumed at the first edge with `out_ready=1` in DONE.
  - `in_ready` rises the cycle after that edge.
  - Minimum spacing between accepts is NIB+2 cycles.
- **No combinational paths:** nothing passes from `in_valid` or `out_ready` to any output except through state. `in_ready` and `out_valid` are decoded directly from the state register.
- **Reset mid-operation (RUN or DONE):** the operation is abandoned with no `out_valid` pulse. Any partial `sum` is cleared to 0.
- **Simultaneous events:** `out_ready` high in IDLE or RUN has no effect. `in_valid` and `out_ready` both high in DONE completes only the current result; a new accept waits for IDLE.

## Structure
- **Shared package (`adder_pkg`):** holds the state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`) and the constant `SLICE_W = 4`.
- **Sub-module:** exactly one instance of `carry_lookahead_4bit`. The block's carry-out comes from the instance's `Pg`/`Gg` outputs; no second adder is written inline.
- **Control:** FSM, index counter and result registers all live in the top module.

## Test plan
- **Basic add (WIDTH=16):** `a=0x1234`, `b=0x4321`, `cin=0` → `sum=0x5555`, `cout=0`, `overflow=0`; `out_valid` rises exactly 4 cycles after the accept edge.
- **Full carry ripple across cycles:** `a=0xFFFF`, `b=0x0001`, `cin=0` → `sum=0x0000`, `cout=1`, `overflow=0`. Also `a=0xFFFF`, `b=0x0000`, `cin=1` → `sum=0x0000`, `cout=1`.
- **Signed overflow:**
  - `a=0x7FFF`, `b=0x0001` → `sum=0x8000`, `overflow=1`, `cout=0`.
  - `a=0x8000`, `b=0x8000` → `sum=0x0000`, `overflow=1`, `cout=1`.
- **Backpressure:**
  - Hold `out_ready=0` for 5 cycles in DONE → outputs stable and `in_ready=0` throughout.
  - Toggle `a` and `b` during RUN → result unchanged.
- **Reset mid-RUN:**
  - Assert `rst_n=0` for one edge after 2 nibbles → `out_valid` never rises; `in_ready=1` the cycle after release; `sum=0`.
  - A following operation `0x00FF+0x0001` gives `0x0100`.
- **WIDTH=4 instance:** `a=0xF`, `b=0xF`, `cin=1` → `sum=0xF`, `cout=1`, `overflow=0`; `out_valid` rises 1 cycle after the accept edge.
